// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - quadrature phase encodings, direction codes and step decode
// Shared by the quadrature decoder top and its bench.
package quad_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  typedef struct packed {
    logic valid;
    logic illegal;
    logic up;
  } step_t;

  // Position of a phase along the up sequence 00->01->11->10.
  function automatic logic [1:0] phase_idx(input logic [1:0] ph);
    case (ph)
      PH_00:   return 2'd0;
      PH_01:   return 2'd1;
      PH_11:   return 2'd2;
      PH_10:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic step_t decode_step(input logic [1:0] prev, input logic [1:0] cur);
    step_t      s;
    logic [1:0] diff;
    diff      = prev ^ cur;
    s.valid   = ^diff;
    s.illegal = &diff;
    s.up      = s.valid && (phase_idx(cur) == phase_idx(prev) + 2'd1);
    return s;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop synchronizer for one asynchronous input bit
// Plain flop chain cleared by the synchronous reset.
module bit_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d};
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/quad_updown_decoder.sv
// rtl/quad_updown_decoder.sv - quadrature A/B decoder with wrapping up/down position counter
// Synchronizes the pins, decodes Gray steps and keeps position, direction and a sticky error.
module quad_updown_decoder
  import quad_pkg::*;
#(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a_in,
  input  logic             b_in,
  output logic [WIDTH-1:0] pos,
  output logic             dir,
  output logic             step,
  output logic             wrap,
  output logic             err
);

  localparam int WARM_W = $clog2(SYNC_STAGES + 2);
  localparam logic [WARM_W-1:0] WARM_LOAD = WARM_W'(SYNC_STAGES + 1);
  localparam logic [WIDTH-1:0]  POS_MAX   = '1;

  logic             a_s, b_s;
  logic [1:0]       phase;
  step_t            st;

  logic [1:0]        prev_q;
  logic [WARM_W-1:0] warm_q, warm_d;
  logic [WIDTH-1:0]  pos_q, pos_d;
  logic              dir_q, dir_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              err_q, err_d;

  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_a (.clk(clk), .rst(rst), .d(a_in), .q(a_s));
  bit_sync #(.STAGES(SYNC_STAGES)) u_sync_b (.clk(clk), .rst(rst), .d(b_in), .q(b_s));

  assign phase = {a_s, b_s};
  assign st    = decode_step(prev_q, phase);

  // Warm-up lets the synchronizers fill with real pin levels before any comparison counts.
  always_comb begin
    warm_d = (warm_q != '0) ? warm_q - WARM_W'(1) : warm_q;
    pos_d  = pos_q;
    dir_d  = dir_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    err_d  = err_q;
    if (clr) begin
      pos_d = '0;
      dir_d = DIR_DN;
      err_d = 1'b0;
    end else if (warm_q == '0 && en) begin
      if (st.illegal) begin
        err_d = 1'b1;
      end else if (st.valid) begin
        pos_d  = st.up ? pos_q + WIDTH'(1) : pos_q - WIDTH'(1);
        dir_d  = st.up ? DIR_UP : DIR_DN;
        step_d = 1'b1;
        wrap_d = st.up ? (pos_q == POS_MAX) : (pos_q == '0);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= PH_00;
      warm_q <= WARM_LOAD;
      pos_q  <= '0;
      dir_q  <= DIR_DN;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      prev_q <= phase;
      warm_q <= warm_d;
      pos_q  <= pos_d;
      dir_q  <= dir_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end

  assign pos  = pos_q;
  assign dir  = dir_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign err  = err_q;

endmodule

// File: tb/tb_quad_updown_decoder.sv
// tb/tb_quad_updown_decoder.sv - table-driven scoreboard bench for quad_updown_decoder
// Vectors hold pin phase, controls and expected counter state; step pulses are scoreboarded.
module tb_quad_updown_decoder;

  localparam int WIDTH = 4;
  localparam int SYNC  = 2;
  localparam int GAP   = 6;

  logic             clk = 1'b0;
  logic             rst, en, clr, a_in, b_in;
  logic [WIDTH-1:0] pos;
  logic             dir, step, wrap, err;

  always #5 clk = ~clk;

  quad_updown_decoder #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a_in(a_in), .b_in(b_in),
    .pos(pos), .dir(dir), .step(step), .wrap(wrap), .err(err)
  );

  typedef struct {
    logic [1:0]       ph;
    logic             en;
    logic             clr;
    logic [WIDTH-1:0] pos;
    logic             dir;
    logic             stp;
    logic             wrap;
    logic             err;
  } vec_t;

  typedef struct {
    logic [WIDTH-1:0] pos;
    logic             dir;
    logic             wrap;
    int               cyc;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t tbl[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   cyc        = 0;
  int   pushes     = 0;
  int   seen       = 0;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    #1;
    if (step) begin
      seen++;
      if (sbq.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_step: got step at cycle %0d pos=%0d expected no step", cyc, pos);
      end else begin
        mon_e = sbq.pop_front();
        chk("step_pos", int'(pos), int'(mon_e.pos));
        chk("step_dir", int'(dir), int'(mon_e.dir));
        chk("step_wrap", int'(wrap), int'(mon_e.wrap));
        chk("step_latency_cycle", cyc, mon_e.cyc);
      end
    end else if (wrap) begin
      chk("wrap_without_step", int'(wrap), 0);
    end
  end

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    @(negedge clk);
    {a_in, b_in} = v.ph;
    en  = v.en;
    clr = v.clr;
    if (v.stp) begin
      e.pos  = v.pos;
      e.dir  = v.dir;
      e.wrap = v.wrap;
      e.cyc  = cyc + SYNC + 1;
      sbq.push_back(e);
      pushes++;
    end
    @(negedge clk);
    clr = 1'b0;
    repeat (GAP - 1) @(negedge clk);
    chk($sformatf("vec%0d_pos", idx), int'(pos), int'(v.pos));
    chk($sformatf("vec%0d_dir", idx), int'(dir), int'(v.dir));
    chk($sformatf("vec%0d_err", idx), int'(err), int'(v.err));
  endtask

  initial begin
    //               ph    en    clr   pos    dir   stp   wrap  err
    tbl.push_back('{2'b10, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1'b0, 4'd4,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd5,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1'b0, 4'd6,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b0, 4'd7,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1'b0, 4'd8,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b0, 4'd15, 1'b0, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{2'b00, 1'b1, 1'b0, 4'd0,  1'b1, 1'b1, 1'b1, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b1, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{2'b00, 1'b1, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd3,  1'b1, 1'b1, 1'b0, 1'b1});
    tbl.push_back('{2'b01, 1'b1, 1'b1, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b10, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd0,  1'b0, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b11, 1'b1, 1'b0, 4'd1,  1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{2'b00, 1'b0, 1'b0, 4'd1,  1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{2'b01, 1'b1, 1'b0, 4'd2,  1'b1, 1'b1, 1'b0, 1'b0});

    // Reset with pins held at 11 through warm-up: nothing may count.
    rst = 1'b1; en = 1'b1; clr = 1'b0; a_in = 1'b1; b_in = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_pos", int'(pos), 0);
    chk("reset_dir", int'(dir), 0);
    chk("reset_step", int'(step), 0);
    chk("reset_wrap", int'(wrap), 0);
    chk("reset_err", int'(err), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("warmup_pos", int'(pos), 0);
    chk("warmup_err", int'(err), 0);

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // clr lands on the very edge at which the 01->11 step would count.
    @(negedge clk);
    {a_in, b_in} = 2'b11;
    en = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (GAP) @(negedge clk);
    chk("clr_vs_step_pos", int'(pos), 0);
    chk("clr_vs_step_dir", int'(dir), 0);
    chk("clr_vs_step_err", int'(err), 0);

    // Reset while an 11->10 edge is still inside the synchronizer.
    @(negedge clk);
    {a_in, b_in} = 2'b10;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midrst_pos", int'(pos), 0);
    chk("midrst_step", int'(step), 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    chk("post_rst_pos", int'(pos), 0);
    chk("post_rst_err", int'(err), 0);
    apply('{2'b00, 1'b1, 1'b0, 4'd1, 1'b1, 1'b1, 1'b0, 1'b0}, 99);

    repeat (10) @(negedge clk);
    chk("scoreboard_drained", sbq.size(), 0);
    chk("step_pulse_total", seen, pushes);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
